// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//
// Handshake bundle for the bit-serial adder.
//
// Signals:
//   in_valid  operand beat valid
//   in_ready  adder can accept operands
//   a, b      WIDTH-bit operands
//   cin       carry-in for bit 0
//   sub       subtract select (present only when SERIAL_ADDER_SUB_EN is defined)
//   out_valid result valid
//   out_ready downstream accepts the result
//   sum       WIDTH-bit result (0 while out_valid is low)
//   cout      carry-out of the top bit (0 while out_valid is low)
//
// Modports:
//   master : operand producer / result consumer
//   slave  : the adder itself
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 'sub' signal.
// -----------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout
    );
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. Operands are captured on an in_valid/in_ready handshake,
// then added LSB-first one bit per clock through a single full-adder cell whose
// carry-out is registered and fed back as the next bit's carry-in. After WIDTH
// bit-cycles the WIDTH-bit result and final carry are held on an
// out_valid/out_ready handshake until the consumer takes them.
//
// Ports:
//   clk    single clock, all state updates on posedge
//   reset  asynchronous, active-high; discards any in-flight operation
//   bus    serial_adder_if.slave: operand and result handshakes
//   busy   high while an operation is running or its result is waiting
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, bus.sub=1 at the operand handshake loads ~b with carry-in 1,
//   giving a-b mod 2^WIDTH with cout=1 meaning "no borrow" (a >= b unsigned).
//   When undefined the block is add-only.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus,
    output logic          busy
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic               fa_sum;
    logic               fa_cout;

    // One-bit full-adder cell: returns {cout, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (x & ci) | (y & ci);
        return {co, s};
    endfunction

    // The cell always looks at the LSBs of the shifters; its output is only
    // consumed while in RUN.
    assign {fa_cout, fa_sum} = full_add(a_sh_q[0], b_sh_q[0], carry_q);

    // State register. Reset clears the whole datapath so an aborted operation
    // leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
                    // Two's-complement subtract: a + ~b + 1; cin is ignored.
                    if (bus.sub) begin
                        b_sh_d  = ~bus.b;
                        carry_d = 1'b1;
                    end else begin
                        b_sh_d  = bus.b;
                        carry_d = bus.cin;
                    end
`else
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Result bits enter at the MSB so that after WIDTH shifts
                // bit 0 has reached position 0.
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    // Hold the counter at its last value instead of wrapping.
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from the state register so that reset takes
    // effect on them without waiting for a clock edge.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = (state_q == DONE) ? sum_sh_q : '0;
    assign bus.cout      = (state_q == DONE) ? carry_q  : 1'b0;
    assign busy          = (state_q != IDLE);

endmodule
